// File: rtl/rx_serial_n.sv
// rx_serial_n: oversampling asynchronous serial receiver for N-bit LSB-first frames.
// Define PARITY_EN to expect an odd-parity bit between the data bits and the stop bit.
module rx_serial_n #(
    parameter int N            = 7,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         dado_serial,
    output logic [N-1:0] dado_recebido,
    output logic         pronto,
    output logic         paridade_ok,
    output logic         erro_frame,
    output logic         recebendo,
    output logic [3:0]   db_estado
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(N + 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(N - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_START     = 4'd1;
    localparam logic [3:0] S_DATA      = 4'd2;
    localparam logic [3:0] S_STOP      = 4'd4;
    localparam logic [3:0] S_DONE      = 4'd5;
    localparam logic [3:0] S_WAIT_IDLE = 4'd6;
`ifdef PARITY_EN
    localparam logic [3:0] S_PARITY     = 4'd3;
    localparam logic [3:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [3:0] S_AFTER_DATA = S_STOP;
`endif

    logic          rx_sync_p0;
    logic          rx_sync_p1;
    logic          line_prev_p2;
    logic [3:0]    state;
    logic [TW-1:0] tick;
    logic [BW-1:0] bit_cnt;
    logic [N-1:0]  shift_reg;
    logic          tick_full;
`ifdef PARITY_EN
    logic          parity_bit;

    function automatic logic odd_parity_ok(input logic [N:0] bits);
        return ^bits;
    endfunction
`endif

    assign tick_full = (tick == TICK_FULL);
    assign recebendo = (state != S_IDLE);
    assign db_estado = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sync_p0    <= 1'b1;
            rx_sync_p1    <= 1'b1;
            line_prev_p2  <= 1'b1;
            state         <= S_IDLE;
            tick          <= '0;
            bit_cnt       <= '0;
            pronto        <= 1'b0;
            erro_frame    <= 1'b0;
            dado_recebido <= '0;
            paridade_ok   <= 1'b1;
        end else begin
            // stage p0/p1: metastability guard; p2: previous synced level for edge detect
            rx_sync_p0   <= dado_serial;
            rx_sync_p1   <= rx_sync_p0;
            line_prev_p2 <= rx_sync_p1;
            pronto       <= 1'b0;
            erro_frame   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (line_prev_p2 && !rx_sync_p1) begin
                        state <= S_START;
                        tick  <= '0;
                    end
                end
                S_START: begin
                    if (tick == TICK_HALF) begin
                        tick    <= '0;
                        bit_cnt <= '0;
                        state   <= rx_sync_p1 ? S_IDLE : S_DATA;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_full) begin
                        tick <= '0;
                        if (bit_cnt == LAST_BIT) state <= S_AFTER_DATA;
                        else bit_cnt <= bit_cnt + BW'(1);
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    if (tick_full) begin
                        tick  <= '0;
                        state <= S_STOP;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick_full) begin
                        tick <= '0;
                        if (rx_sync_p1) begin
                            state <= S_DONE;
                        end else begin
                            state      <= S_WAIT_IDLE;
                            erro_frame <= 1'b1;
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                S_DONE: begin
                    dado_recebido <= shift_reg;
`ifdef PARITY_EN
                    paridade_ok   <= odd_parity_ok({shift_reg, parity_bit});
`else
                    paridade_ok   <= 1'b1;
`endif
                    pronto        <= 1'b1;
                    state         <= S_IDLE;
                end
                S_WAIT_IDLE: begin
                    // a stuck-low line must go high before a new start edge is accepted
                    if (rx_sync_p1) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // datapath capture at each mid-bit sample; new bit enters at the MSB
    always_ff @(posedge clock) begin
        if (tick_full && state == S_DATA)
            shift_reg <= (shift_reg >> 1) | (N'(rx_sync_p1) << (N - 1));
`ifdef PARITY_EN
        if (tick_full && state == S_PARITY)
            parity_bit <= rx_sync_p1;
`endif
    end

endmodule

// File: tb/tb_rx_serial_n.sv
// tb_rx_serial_n: table-driven, directed and randomized checks of rx_serial_n.
// Works with PARITY_EN defined or undefined; bit period shortened to keep runs short.
module tb_rx_serial_n;
    localparam int N   = 7;
    localparam int CPB = 41;
`ifdef PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         dado_serial = 1'b1;
    logic [N-1:0] dado_recebido;
    logic         pronto;
    logic         paridade_ok;
    logic         erro_frame;
    logic         recebendo;
    logic [3:0]   db_estado;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    rx_serial_n #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .dado_serial  (dado_serial),
        .dado_recebido(dado_recebido),
        .pronto       (pronto),
        .paridade_ok  (paridade_ok),
        .erro_frame   (erro_frame),
        .recebendo    (recebendo),
        .db_estado    (db_estado)
    );

    typedef struct packed {
        logic         is_err;
        logic [N-1:0] data;
        logic         pok;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    bit  both_seen = 1'b0;
    logic [N-1:0] exp_last_data = '0;
    logic         exp_last_pok  = 1'b1;

    always @(negedge clock) begin
        if (pronto)     obs_q.push_back('{1'b0, dado_recebido, paridade_ok});
        if (erro_frame) obs_q.push_back('{1'b1, {N{1'b0}}, 1'b0});
        if (pronto && erro_frame) both_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int cycles);
        dado_serial = v;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    // Reference: a frame with stop=1 yields one pronto with its data and odd-parity
    // verdict; stop=0 yields one erro_frame and leaves the held outputs alone.
    task automatic send_frame(input logic [N-1:0] d, input logic par_good, input logic stop);
        logic pbit;
        pbit = par_good ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
        drive(1'b0, CPB);
        for (int i = 0; i < N; i++) drive(d[i], CPB);
        if (PAR_EN) drive(pbit, CPB);
        drive(stop, CPB);
        if (stop) begin
            exp_last_data = d;
            exp_last_pok  = PAR_EN ? ($countones({d, pbit}) % 2 == 1) : 1'b1;
            exp_q.push_back('{1'b0, d, exp_last_pok});
        end else begin
            exp_q.push_back('{1'b1, {N{1'b0}}, 1'b0});
        end
    endtask

    task automatic verify_events(input string tag);
        check({tag, " event count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, " event"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [N-1:0] data;
        logic         par_good;
        logic         stop;
        int           exp_pronto;
        int           exp_err;
        logic [N-1:0] exp_data;
        logic         exp_pok;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{7'h35, 1'b1, 1'b1, 1, 0, 7'h35, 1'b1};
        vecs[1] = '{7'h35, 1'b0, 1'b1, 1, 0, 7'h35, PAR_EN ? 1'b0 : 1'b1};
        vecs[2] = '{7'h41, 1'b1, 1'b0, 0, 1, 7'h35, PAR_EN ? 1'b0 : 1'b1};
        vecs[3] = '{7'h22, 1'b1, 1'b1, 1, 0, 7'h22, 1'b1};
        vecs[4] = '{7'h7F, 1'b1, 1'b1, 1, 0, 7'h7F, 1'b1};
        vecs[5] = '{7'h00, 1'b0, 1'b1, 1, 0, 7'h00, PAR_EN ? 1'b0 : 1'b1};
        vecs[6] = '{7'h55, 1'b1, 1'b1, 1, 0, 7'h55, 1'b1};
        vecs[7] = '{7'h12, 1'b1, 1'b1, 1, 0, 7'h12, 1'b1};

        // reset values while reset is held
        repeat (3) @(posedge clock);
        #1;
        check("reset dado_recebido", dado_recebido, 0);
        check("reset pronto", pronto, 0);
        check("reset erro_frame", erro_frame, 0);
        check("reset paridade_ok", paridade_ok, 1);
        check("reset recebendo", recebendo, 0);
        check("reset db_estado", db_estado, 0);
        reset = 1'b0;
        drive(1'b1, CPB);

        // table-driven single frames, each followed by two idle bit times
        for (int v = 0; v < 8; v++) begin
            int np, ne;
            obs_q.delete();
            send_frame(vecs[v].data, vecs[v].par_good, vecs[v].stop);
            drive(1'b1, 2 * CPB);
            np = 0;
            ne = 0;
            foreach (obs_q[k]) begin
                if (obs_q[k].is_err) ne++;
                else np++;
            end
            check($sformatf("vec%0d pronto count", v), np, vecs[v].exp_pronto);
            check($sformatf("vec%0d erro count", v), ne, vecs[v].exp_err);
            check($sformatf("vec%0d dado_recebido", v), dado_recebido, vecs[v].exp_data);
            check($sformatf("vec%0d paridade_ok", v), paridade_ok, vecs[v].exp_pok);
            check($sformatf("vec%0d recebendo idle", v), recebendo, 0);
            obs_q.delete();
            exp_q.delete();
        end

        // short low glitch is rejected at the start-bit midpoint
        drive(1'b0, 6);
        check("glitch recebendo high", recebendo, 1);
        drive(1'b0, CPB / 4 - 6);
        drive(1'b1, 2 * CPB);
        check("glitch db_estado", db_estado, 0);
        check("glitch dado_recebido", dado_recebido, exp_last_data);
        verify_events("glitch");

        // bad stop bit, line stuck low, then a clean frame
        send_frame(7'h41, 1'b1, 1'b0);
        drive(1'b0, 2 * CPB);
        check("stuck low db_estado", db_estado, 6);
        check("stuck low dado_recebido", dado_recebido, 7'h12);
        drive(1'b1, CPB);
        send_frame(7'h22, 1'b1, 1'b1);
        drive(1'b1, 2 * CPB);
        verify_events("frame error");
        check("after error dado_recebido", dado_recebido, 7'h22);

        // back-to-back frames with no idle gap
        send_frame(7'h7F, 1'b1, 1'b1);
        send_frame(7'h00, 1'b1, 1'b1);
        send_frame(7'h55, 1'b1, 1'b1);
        drive(1'b1, 2 * CPB);
        verify_events("back-to-back");

        // reset in the middle of the data bits aborts the frame
        drive(1'b0, CPB);
        drive(1'b1, 3 * CPB);
        check("mid-frame recebendo", recebendo, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid reset dado_recebido", dado_recebido, 0);
        check("mid reset paridade_ok", paridade_ok, 1);
        check("mid reset recebendo", recebendo, 0);
        check("mid reset db_estado", db_estado, 0);
        check("mid reset pronto", pronto, 0);
        exp_last_data = '0;
        exp_last_pok  = 1'b1;
        drive(1'b1, (N + 3) * CPB);
        verify_events("aborted frame");
        send_frame(7'h12, 1'b1, 1'b1);
        drive(1'b1, 2 * CPB);
        verify_events("post-reset frame");
        check("post-reset dado_recebido", dado_recebido, 7'h12);

        // randomized frames against the reference
        for (int r = 0; r < 20; r++) begin
            logic [N-1:0] d;
            logic         pg, st;
            int           gap;
            d   = N'($urandom_range(0, (1 << N) - 1));
            pg  = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b1;
            st  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2);
            if (!st && gap == 0) gap = 1;
            send_frame(d, pg, st);
            drive(1'b1, gap * CPB);
        end
        drive(1'b1, 2 * CPB);
        verify_events("random");
        check("random final dado_recebido", dado_recebido, exp_last_data);
        check("random final paridade_ok", paridade_ok, exp_last_pok);
        check("pronto and erro_frame exclusive", both_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
